rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the in-order WB path and a multi-cycle M-extension divider that completes out of order.
- Buffers divider results in a small FIFO and grants WB absolute priority.
- Keeps a per-register busy scoreboard so the ID stage can stall on RAW/WAW hazards against pending divider results.
- Sits between the MEM/WB register, the divider, and reg_file's write port; id_stall_o feeds the hazard unit.

Parameters:
FIFO_DEPTH, 2, divider result buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wb_reg_write_i  input  1  WB write request
wb_rd_addr_i  input  5  WB destination
wb_data_i  input  32  WB data
div_valid_i  input  1  divider result valid
div_ready_o  output  1  arbiter can accept divider result
div_rd_addr_i  input  5  divider result destination
div_data_i  input  32  divider result data
issue_i  input  1  ID issued a div/rem to divider this cycle (not stalled)
issue_rd_i  input  5  destination of issued div/rem
id_rs1_addr_i  input  5  ID rs1
id_rs2_addr_i  input  5  ID rs2
id_rd_addr_i  input  5  ID rd
id_stall_o  output  1  ID must hold (hazard on pending divider result)
rf_wen_o  output  1  registered write enable to reg_file
rf_rd_addr_o  output  5  registered write address
rf_rd_data_o  output  32  registered write data
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen_o=0, rf_rd_addr_o=0, rf_rd_data_o=0.
  - FIFO emptied; fifo_count_o=0.
  - All 31 busy bits cleared.
  - id_stall_o=0; div_ready_o=1 (it is !full, derived combinationally from registered count).
- Reset mid-operation discards buffered results and busy state. The divider is reset by the same rst_n.
- Divider handshake:
  - Transfer occurs when div_valid_i && div_ready_o.
  - div_ready_o = (count < FIFO_DEPTH).
  - A full FIFO that drains in the same cycle still reports not-ready; there is no combinational ready-from-pop path.
- Port grant, evaluated each cycle, registered at the next edge:
  - wb_reg_write_i=1: rf_* <= WB values; FIFO head is not popped.
  - else FIFO non-empty: rf_* <= head; pop; clear busy[head.rd].
  - else rf_wen_o <= 0. Address and data hold their last value.
- Writes with rd=0 are never presented: rf_wen_o is 0 for them. A FIFO entry with rd=0 is still popped.
- Latency:
  - WB to rf_wen_o: 1 cycle.
  - Divider accept (cycle N) to rf_wen_o: earliest N+2. It is delayed one cycle per WB write while the entry is at the head.
- FIFO ordering is strict: entries are written to the register file in arrival order.
- Simultaneous push and pop:
  - Allowed when count>0; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - busy[r] is set on issue_i when issue_rd_i != 0.
  - busy[r] is cleared when a FIFO entry with rd=r is granted.
  - If set and clear for the same r occur in the same cycle, set wins.
- id_stall_o is combinational: busy[id_rs1_addr_i] | busy[id_rs2_addr_i] | busy[id_rd_addr_i] (RAW and WAW). Index 0 always reads not-busy.
- id_stall_o also asserts when count==FIFO_DEPTH, so new divider work is throttled while the buffer is full.
- WB never targets a busy rd. This is guaranteed by the WAW stall; the arbiter does not check it.

Optional Feature:
Macro name: RF_ARB_BYPASS_EN.
- Defined: when FIFO empty, wb_reg_write_i=0 and a divider transfer occurs, the result goes directly into rf_* at that edge.
  - The FIFO is not written and the busy bit is cleared at that edge.
  - Divider-to-rf_wen_o latency becomes 1 cycle.
- Undefined: every divider result passes through the FIFO, with minimum latency 2.

Test Plan:
- Reset release, idle -> rf_wen_o=0, div_ready_o=1, id_stall_o=0, fifo_count_o=0.
- WB write x5=0x0000_00AA -> next cycle rf_wen_o=1, rf_rd_addr_o=5, rf_rd_data_o=0xAA.
- issue_i with rd=7, then ID presents rs1=7 -> id_stall_o=1.
  - Divider returns x7=0x1234 at cycle N with WB idle -> rf write at N+2 (N+1 with RF_ARB_BYPASS_EN).
  - id_stall_o drops the cycle after the write.
- WB writes every cycle for 4 cycles while the divider pushes x3 then x4 -> fifo_count_o reaches 2 and div_ready_o=0.
  - After WB idles, x3 then x4 are written on consecutive cycles, in order.
- Divider result to x0 -> popped, rf_wen_o stays 0, fifo_count_o returns to 0.
- Assert rst_n=0 with 2 FIFO entries and busy[9] set -> outputs zero immediately.
  - After release: FIFO empty, id_stall_o=0 for rs1=9.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, divider results queue in a small FIFO,
// and a per-register busy scoreboard stalls ID. Optional RF_ARB_BYPASS_EN writes a divider result straight through when idle.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_reg_write_i,
  input  logic [4:0]                    wb_rd_addr_i,
  input  logic [31:0]                   wb_data_i,
  input  logic                          div_valid_i,
  output logic                          div_ready_o,
  input  logic [4:0]                    div_rd_addr_i,
  input  logic [31:0]                   div_data_i,
  input  logic                          issue_i,
  input  logic [4:0]                    issue_rd_i,
  input  logic [4:0]                    id_rs1_addr_i,
  input  logic [4:0]                    id_rs2_addr_i,
  input  logic [4:0]                    id_rd_addr_i,
  output logic                          id_stall_o,
  output logic                          rf_wen_o,
  output logic [4:0]                    rf_rd_addr_o,
  output logic [31:0]                   rf_rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   busy_q, busy_d;
  logic          rf_wen_q, rf_wen_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];

  logic          full, empty, push, pop, bypass, push_fifo;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    push      = div_valid_i && !full;
`ifdef RF_ARB_BYPASS_EN
    bypass    = push && empty && !wb_reg_write_i;
`else
    bypass    = 1'b0;
`endif
    pop       = !wb_reg_write_i && !empty;
    push_fifo = push && !bypass;
    head_rd   = fifo_rd_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];

    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_reg_write_i) begin
      rf_wen_d  = (wb_rd_addr_i != 5'd0);
      rf_addr_d = wb_rd_addr_i;
      rf_data_d = wb_data_i;
    end else if (pop) begin
      rf_wen_d  = (head_rd != 5'd0);
      rf_addr_d = head_rd;
      rf_data_d = head_data;
    end else if (bypass) begin
      rf_wen_d  = (div_rd_addr_i != 5'd0);
      rf_addr_d = div_rd_addr_i;
      rf_data_d = div_data_i;
    end

    // Clears first so a same-cycle issue to the same register keeps it busy.
    busy_d = busy_q;
    if (pop)    busy_d[head_rd]       = 1'b0;
    if (bypass) busy_d[div_rd_addr_i] = 1'b0;
    if (issue_i && (issue_rd_i != 5'd0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    count_d  = count_q + CW'(push_fifo) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push_fifo);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      busy_q    <= '0;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      busy_q    <= busy_d;
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Buffer storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      fifo_rd_q[wr_ptr_q]   <= div_rd_addr_i;
      fifo_data_q[wr_ptr_q] <= div_data_i;
    end
  end

  assign div_ready_o  = !full;
  assign id_stall_o   = full | busy_q[id_rs1_addr_i] | busy_q[id_rs2_addr_i] | busy_q[id_rd_addr_i];
  assign rf_wen_o     = rf_wen_q;
  assign rf_rd_addr_o = rf_addr_q;
  assign rf_rd_data_o = rf_data_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table plus hand sequences for latency, wrap, x0 and reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_reg_write_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [4:0]  div_rd_addr_i;
  logic [31:0] div_data_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_stall_o;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  logic [1:0]  fifo_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  rf_write_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_rd_addr_i(div_rd_addr_i), .div_data_i(div_data_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_stall_o(id_stall_o),
    .rf_wen_o(rf_wen_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
    .fifo_count_o(fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dv;
    logic [4:0]  div_rd;
    logic [31:0] div_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic        e_wen;
    logic        chk_ad;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_reg_write_i = 0; wb_rd_addr_i = 0; wb_data_i = 0;
    div_valid_i = 0; div_rd_addr_i = 0; div_data_i = 0;
    issue_i = 0; issue_rd_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
  endtask

  task automatic chk_state(input string tag, input logic wen, input logic [1:0] cnt, input logic stall);
    chk({tag, ".wen"},   32'(rf_wen_o),     32'(wen));
    chk({tag, ".cnt"},   32'(fifo_count_o), 32'(cnt));
    chk({tag, ".stall"}, 32'(id_stall_o),   32'(stall));
  endtask

  initial begin
    //          wb rd  data      dv rd  data      iss rd rs1  wen ad addr data      cnt rdy stall
    vecs[0]  = '{0, 0,  32'h0,   0, 0,  32'h0,   0, 0, 0,    0, 1, 0,  32'h0,   0, 1, 0};
    vecs[1]  = '{1, 5,  32'hAA,  0, 0,  32'h0,   0, 0, 0,    1, 1, 5,  32'hAA,  0, 1, 0};
    vecs[2]  = '{0, 0,  32'h0,   0, 0,  32'h0,   0, 0, 0,    0, 1, 5,  32'hAA,  0, 1, 0};
    vecs[3]  = '{1, 0,  32'h55,  0, 0,  32'h0,   0, 0, 0,    0, 0, 0,  32'h0,   0, 1, 0};
    vecs[4]  = '{0, 0,  32'h0,   0, 0,  32'h0,   1, 3, 3,    0, 0, 0,  32'h0,   0, 1, 1};
    vecs[5]  = '{1, 10, 32'h100, 1, 3,  32'h333, 1, 4, 4,    1, 1, 10, 32'h100, 1, 1, 1};
    vecs[6]  = '{1, 11, 32'h101, 1, 4,  32'h444, 0, 0, 0,    1, 1, 11, 32'h101, 2, 0, 1};
    vecs[7]  = '{1, 12, 32'h102, 1, 9,  32'h999, 0, 0, 0,    1, 1, 12, 32'h102, 2, 0, 1};
    vecs[8]  = '{1, 13, 32'h103, 0, 0,  32'h0,   0, 0, 0,    1, 1, 13, 32'h103, 2, 0, 1};
    vecs[9]  = '{0, 0,  32'h0,   0, 0,  32'h0,   0, 0, 3,    1, 1, 3,  32'h333, 1, 1, 0};
    vecs[10] = '{0, 0,  32'h0,   0, 0,  32'h0,   0, 0, 4,    1, 1, 4,  32'h444, 0, 1, 0};
    vecs[11] = '{0, 0,  32'h0,   0, 0,  32'h0,   0, 0, 0,    0, 1, 4,  32'h444, 0, 1, 0};

    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst.wen",   32'(rf_wen_o),     32'd0);
    chk("rst.addr",  32'(rf_rd_addr_o), 32'd0);
    chk("rst.data",  rf_rd_data_o,      32'd0);
    chk("rst.cnt",   32'(fifo_count_o), 32'd0);
    chk("rst.rdy",   32'(div_ready_o),  32'd1);
    chk("rst.stall", 32'(id_stall_o),   32'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < 12; i++) begin
      wb_reg_write_i = vecs[i].wb; wb_rd_addr_i = vecs[i].wb_rd; wb_data_i = vecs[i].wb_data;
      div_valid_i = vecs[i].dv; div_rd_addr_i = vecs[i].div_rd; div_data_i = vecs[i].div_data;
      issue_i = vecs[i].iss; issue_rd_i = vecs[i].iss_rd; id_rs1_addr_i = vecs[i].rs1;
      tick();
      chk($sformatf("v%0d.wen", i),   32'(rf_wen_o),     32'(vecs[i].e_wen));
      if (vecs[i].chk_ad) begin
        chk($sformatf("v%0d.addr", i), 32'(rf_rd_addr_o), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d.data", i), rf_rd_data_o,      vecs[i].e_data);
      end
      chk($sformatf("v%0d.cnt", i),   32'(fifo_count_o), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d.rdy", i),   32'(div_ready_o),  32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.stall", i), 32'(id_stall_o),   32'(vecs[i].e_stall));
    end

    // Divider latency and scoreboard on rs1/rs2/rd.
    idle_inputs();
    issue_i = 1; issue_rd_i = 7;
    tick();
    issue_i = 0; id_rs1_addr_i = 7;
    #1 chk("s1.raw_rs1", 32'(id_stall_o), 32'd1);
    id_rs1_addr_i = 0; id_rs2_addr_i = 7;
    #1 chk("s1.raw_rs2", 32'(id_stall_o), 32'd1);
    id_rs2_addr_i = 0; id_rd_addr_i = 7;
    #1 chk("s1.waw_rd", 32'(id_stall_o), 32'd1);
    @(posedge clk); #1;
    div_valid_i = 1; div_rd_addr_i = 7; div_data_i = 32'h1234;
    tick();
    div_valid_i = 0;
`ifdef RF_ARB_BYPASS_EN
    chk_state("s1.n1", 1, 0, 0);
    chk("s1.addr", 32'(rf_rd_addr_o), 32'd7);
    chk("s1.data", rf_rd_data_o, 32'h1234);
    tick();
    chk_state("s1.n2", 0, 0, 0);
`else
    chk_state("s1.n1", 0, 1, 1);
    tick();
    chk_state("s1.n2", 1, 0, 0);
    chk("s1.addr", 32'(rf_rd_addr_o), 32'd7);
    chk("s1.data", rf_rd_data_o, 32'h1234);
`endif
    tick();
    chk_state("s1.n3", 0, 0, 0);

    // Simultaneous push/pop with pointer wrap.
    idle_inputs();
    wb_reg_write_i = 1; wb_rd_addr_i = 20; wb_data_i = 32'h20;
    div_valid_i = 1; div_rd_addr_i = 21; div_data_i = 32'h21;
    tick();
    chk_state("s2.a", 1, 1, 0);
    chk("s2.a.addr", 32'(rf_rd_addr_o), 32'd20);
    wb_reg_write_i = 0; div_rd_addr_i = 22; div_data_i = 32'h22;
    tick();
    chk_state("s2.b", 1, 1, 0);
    chk("s2.b.addr", 32'(rf_rd_addr_o), 32'd21);
    chk("s2.b.data", rf_rd_data_o, 32'h21);
    div_rd_addr_i = 23; div_data_i = 32'h23;
    tick();
    chk_state("s2.c", 1, 1, 0);
    chk("s2.c.addr", 32'(rf_rd_addr_o), 32'd22);
    div_valid_i = 0;
    tick();
    chk_state("s2.d", 1, 0, 0);
    chk("s2.d.data", rf_rd_data_o, 32'h23);

    // Full FIFO draining this cycle still refuses new results.
    wb_reg_write_i = 1; wb_rd_addr_i = 16; wb_data_i = 32'h16;
    div_valid_i = 1; div_rd_addr_i = 24; div_data_i = 32'h24;
    tick();
    wb_rd_addr_i = 17; wb_data_i = 32'h17; div_rd_addr_i = 26; div_data_i = 32'h26;
    tick();
    chk_state("s3.full", 1, 2, 1);
    chk("s3.full.rdy", 32'(div_ready_o), 32'd0);
    wb_reg_write_i = 0; div_rd_addr_i = 25; div_data_i = 32'h25;
    #1 chk("s3.drain.rdy", 32'(div_ready_o), 32'd0);
    tick();
    div_valid_i = 0;
    chk_state("s3.pop1", 1, 1, 0);
    chk("s3.pop1.addr", 32'(rf_rd_addr_o), 32'd24);
    tick();
    chk_state("s3.pop2", 1, 0, 0);
    chk("s3.pop2.addr", 32'(rf_rd_addr_o), 32'd26);
    tick();
    chk_state("s3.idle", 0, 0, 0);

    // Divider results to x0 are consumed without a write.
    wb_reg_write_i = 1; wb_rd_addr_i = 15; wb_data_i = 32'hF;
    div_valid_i = 1; div_rd_addr_i = 0; div_data_i = 32'hDEAD;
    tick();
    chk_state("s4.push", 1, 1, 0);
    wb_reg_write_i = 0; div_valid_i = 0;
    tick();
    chk_state("s4.pop", 0, 0, 0);
    div_valid_i = 1;
    tick();
    div_valid_i = 0;
`ifdef RF_ARB_BYPASS_EN
    chk_state("s4.direct", 0, 0, 0);
`else
    chk_state("s4.direct", 0, 1, 0);
`endif
    tick();
    chk_state("s4.done", 0, 0, 0);

    // Asynchronous reset with buffered results and a busy register.
    idle_inputs();
    issue_i = 1; issue_rd_i = 9;
    wb_reg_write_i = 1; wb_rd_addr_i = 1; wb_data_i = 32'h1;
    div_valid_i = 1; div_rd_addr_i = 2; div_data_i = 32'h2;
    tick();
    issue_i = 0; div_rd_addr_i = 3; div_data_i = 32'h3;
    tick();
    chk("s5.pre.cnt", 32'(fifo_count_o), 32'd2);
    idle_inputs();
    id_rs1_addr_i = 9;
    #2 rst_n = 0;
    #1;
    chk("s5.rst.wen",   32'(rf_wen_o),     32'd0);
    chk("s5.rst.addr",  32'(rf_rd_addr_o), 32'd0);
    chk("s5.rst.data",  rf_rd_data_o,      32'd0);
    chk("s5.rst.cnt",   32'(fifo_count_o), 32'd0);
    chk("s5.rst.rdy",   32'(div_ready_o),  32'd1);
    chk("s5.rst.stall", 32'(id_stall_o),   32'd0);
    tick();
    rst_n = 1;
    tick();
    chk_state("s5.post", 0, 0, 0);
    tick();
    chk_state("s5.post2", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
